// File: rtl/iopmp_pkg.sv
// Route encoding and defaults for the IOPMP request steering block.
package iopmp_pkg;

    typedef enum logic {RouteDev, RouteBlk} steer_route_e;

    localparam int unsigned SteerMaxOutstDflt = 4;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by the IOPMP steering slice.
package tlul_pkg;

    localparam logic [2:0] PutFullData   = 3'h0;
    localparam logic [2:0] Get           = 3'h4;
    localparam logic [2:0] AccessAck     = 3'h0;
    localparam logic [2:0] AccessAckData = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_route_fifo.sv
// In-order FIFO of routes for accepted requests; the head selects the D-channel source.
module tlul_route_fifo
    import iopmp_pkg::*;
#(
    parameter int unsigned Depth = SteerMaxOutstDflt
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  steer_route_e wdata,
    output steer_route_e rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] cnt;
    steer_route_e    mem [Depth];
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt == CntW'(Depth));
    assign empty   = (cnt == '0);
    assign rdata   = mem[rptr];

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/tlul_iopmp_steer.sv
// Zero-latency steering of TL-UL requests to the device or a local responder by IOPMP verdict.
// Define IOPMP_STEER_DENY_CNT_EN to build the saturating denied-request counter.
module tlul_iopmp_steer
    import tlul_pkg::*;
    import iopmp_pkg::*;
#(
    parameter int unsigned MaxOutst = SteerMaxOutstDflt
) (
    input  logic        clk,
    input  logic        rst_n,
    input  tl_h2d_t     req_i,
    output tl_d2h_t     rsp_o,
    input  logic        allow_i,
    output tl_h2d_t     dev_req_o,
    input  tl_d2h_t     dev_rsp_i,
    output tl_h2d_t     blk_req_o,
    input  tl_d2h_t     blk_rsp_i,
    output logic [15:0] deny_cnt_o
);

    steer_route_e route_a;
    steer_route_e route_head;
    tl_d2h_t      head_rsp;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;

    assign route_a = allow_i ? RouteDev : RouteBlk;

    always_comb begin
        dev_req_o = req_i;
        blk_req_o = req_i;
        dev_req_o.a_valid = req_i.a_valid && !fifo_full && (route_a == RouteDev);
        blk_req_o.a_valid = req_i.a_valid && !fifo_full && (route_a == RouteBlk);
        // Only the target owning the oldest outstanding request may complete a D beat.
        dev_req_o.d_ready = req_i.d_ready && !fifo_empty && (route_head == RouteDev);
        blk_req_o.d_ready = req_i.d_ready && !fifo_empty && (route_head == RouteBlk);

        head_rsp = (route_head == RouteDev) ? dev_rsp_i : blk_rsp_i;
        rsp_o = head_rsp;
        rsp_o.d_valid = head_rsp.d_valid && !fifo_empty;
        rsp_o.a_ready = ((route_a == RouteDev) ? dev_rsp_i.a_ready : blk_rsp_i.a_ready)
                        && !fifo_full;
    end

    assign fifo_push = req_i.a_valid && rsp_o.a_ready;
    assign fifo_pop  = rsp_o.d_valid && req_i.d_ready;

    tlul_route_fifo #(
        .Depth (MaxOutst)
    ) u_route_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (route_a),
        .rdata (route_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef IOPMP_STEER_DENY_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] deny_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deny_cnt_q <= '0;
        end else if (fifo_push && (route_a == RouteBlk)) begin
            deny_cnt_q <= sat_inc16(deny_cnt_q);
        end
    end

    assign deny_cnt_o = deny_cnt_q;
`else
    assign deny_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tlul_iopmp_steer.sv
// Directed bench for tlul_iopmp_steer with a D-channel scoreboard fed at request issue.
module tb_tlul_iopmp_steer;
    import tlul_pkg::*;
    import iopmp_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [31:0] data;
        logic        err;
    } beat_t;

`ifdef IOPMP_STEER_DENY_CNT_EN
    localparam bit DenyEn = 1'b1;
`else
    localparam bit DenyEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    tl_h2d_t     req;
    tl_d2h_t     rsp;
    logic        allow;
    tl_h2d_t     dev_req;
    tl_d2h_t     dev_rsp;
    tl_h2d_t     blk_req;
    tl_d2h_t     blk_rsp;
    logic [15:0] deny_cnt;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t mon_act;
    beat_t mon_exp;

    always #5 clk = ~clk;

    tlul_iopmp_steer #(
        .MaxOutst (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .rsp_o      (rsp),
        .allow_i    (allow),
        .dev_req_o  (dev_req),
        .dev_rsp_i  (dev_rsp),
        .blk_req_o  (blk_req),
        .blk_rsp_i  (blk_rsp),
        .deny_cnt_o (deny_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [2:0] op, input logic [7:0] src,
                                      input logic [31:0] data, input logic err);
        beat_t b;
        b.op = op; b.src = src; b.data = data; b.err = err;
        return b;
    endfunction

    function automatic logic [15:0] exp_deny(input int n);
        if (!DenyEn) return 16'h0;
        return (n >= 65535) ? 16'hFFFF : 16'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [7:0] src, input logic [31:0] addr);
        req.a_valid   = 1'b1;
        req.a_opcode  = op;
        req.a_source  = src;
        req.a_address = addr;
        req.a_size    = 2'd2;
        req.a_mask    = 4'hF;
        req.a_data    = 32'h0000_0055;
    endtask

    task automatic dev_beat(input beat_t b);
        dev_rsp.d_valid  = 1'b1;
        dev_rsp.d_opcode = b.op;
        dev_rsp.d_source = b.src;
        dev_rsp.d_data   = b.data;
        dev_rsp.d_error  = b.err;
    endtask

    task automatic blk_beat(input beat_t b);
        blk_rsp.d_valid  = 1'b1;
        blk_rsp.d_opcode = b.op;
        blk_rsp.d_source = b.src;
        blk_rsp.d_data   = b.data;
        blk_rsp.d_error  = b.err;
    endtask

    // Monitor: every host D handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (rsp.d_valid === 1'b1 && req.d_ready === 1'b1) begin
            mon_act = mk_beat(rsp.d_opcode, rsp.d_source, rsp.d_data, rsp.d_error);
            if (exp_q.size() == 0) begin
                check("d_beat_unexpected", 64'(mon_act), 64'h0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("d_beat", 64'(mon_act), 64'(mon_exp));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        req     = '0;
        allow   = 1'b1;
        dev_rsp = '0;
        blk_rsp = '0;
        dev_rsp.a_ready = 1'b1;
        blk_rsp.a_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_d_valid", 64'(rsp.d_valid), 64'd0);
        check("rst_a_ready", 64'(rsp.a_ready), 64'd1);
        check("rst_deny", 64'(deny_cnt), 64'd0);
        dev_rsp.a_ready = 1'b0;
        #1;
        check("rst_a_ready_follows_tgt", 64'(rsp.a_ready), 64'd0);
        dev_rsp.a_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Allowed Get to 0x100, device answers AccessAckData 0xDEADBEEF source 3
        allow = 1'b1;
        drive_a(Get, 8'd3, 32'h0000_0100);
        @(negedge clk);
        check("get_dev_a_valid", 64'(dev_req.a_valid), 64'd1);
        check("get_blk_a_valid", 64'(blk_req.a_valid), 64'd0);
        check("get_dev_addr", 64'(dev_req.a_address), 64'h100);
        check("get_a_ready", 64'(rsp.a_ready), 64'd1);
        exp_q.push_back(mk_beat(AccessAckData, 8'd3, 32'hDEAD_BEEF, 1'b0));
        tick();
        req = '0;
        req.d_ready = 1'b1;
        dev_beat(mk_beat(AccessAckData, 8'd3, 32'hDEAD_BEEF, 1'b0));
        tick();
        @(negedge clk);
        check("empty_hides_d_valid", 64'(rsp.d_valid), 64'd0);
        dev_rsp.d_valid = 1'b0;
        tick();

        // Denied Put goes to the local responder
        allow = 1'b0;
        drive_a(PutFullData, 8'd5, 32'h0000_0200);
        @(negedge clk);
        check("put_dev_a_valid", 64'(dev_req.a_valid), 64'd0);
        check("put_blk_a_valid", 64'(blk_req.a_valid), 64'd1);
        exp_q.push_back(mk_beat(AccessAck, 8'd5, 32'h0, 1'b0));
        tick();
        req.a_valid = 1'b0;
        allow = 1'b1;
        blk_beat(mk_beat(AccessAck, 8'd5, 32'h0, 1'b0));
        tick();
        blk_rsp.d_valid = 1'b0;
        check("deny_one", 64'(deny_cnt), 64'(exp_deny(1)));

        // Fill to MaxOutst with d_ready low, then one pop frees a slot next cycle
        req.d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_a(Get, 8'(8 + i), 32'(32'h300 + 4 * i));
            @(negedge clk);
            check("fill_a_ready", 64'(rsp.a_ready), 64'd1);
            exp_q.push_back(mk_beat(AccessAckData, 8'(8 + i), 32'(32'h1000 + i), 1'b0));
            tick();
        end
        drive_a(Get, 8'd12, 32'h0000_0310);
        @(negedge clk);
        check("full_a_ready", 64'(rsp.a_ready), 64'd0);
        check("full_dev_a_valid", 64'(dev_req.a_valid), 64'd0);
        tick();
        req.d_ready = 1'b1;
        dev_beat(mk_beat(AccessAckData, 8'd8, 32'h1000, 1'b0));
        @(negedge clk);
        check("pop_no_bypass", 64'(rsp.a_ready), 64'd0);
        tick();
        dev_rsp.d_valid = 1'b0;
        req.d_ready = 1'b0;
        @(negedge clk);
        check("after_pop_a_ready", 64'(rsp.a_ready), 64'd1);
        exp_q.push_back(mk_beat(AccessAckData, 8'd12, 32'h1004, 1'b0));
        tick();
        req.a_valid = 1'b0;
        req.d_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            dev_beat(mk_beat(AccessAckData, 8'(8 + j), 32'(32'h1000 + j), 1'b0));
            tick();
        end
        dev_rsp.d_valid = 1'b0;

        // Allow, deny, allow; responder answers before the device
        allow = 1'b1;
        drive_a(Get, 8'd1, 32'h0000_0400);
        exp_q.push_back(mk_beat(AccessAckData, 8'd1, 32'hA1, 1'b0));
        tick();
        allow = 1'b0;
        drive_a(PutFullData, 8'd2, 32'h0000_0404);
        exp_q.push_back(mk_beat(AccessAck, 8'd2, 32'h0, 1'b1));
        tick();
        allow = 1'b1;
        drive_a(Get, 8'd7, 32'h0000_0408);
        exp_q.push_back(mk_beat(AccessAckData, 8'd7, 32'hA7, 1'b0));
        tick();
        req.a_valid = 1'b0;
        blk_beat(mk_beat(AccessAck, 8'd2, 32'h0, 1'b1));
        @(negedge clk);
        check("nonhead_hidden", 64'(rsp.d_valid), 64'd0);
        check("nonhead_d_ready", 64'(blk_req.d_ready), 64'd0);
        tick();
        dev_beat(mk_beat(AccessAckData, 8'd1, 32'hA1, 1'b0));
        tick();
        dev_rsp.d_valid = 1'b0;
        tick();
        blk_rsp.d_valid = 1'b0;
        dev_beat(mk_beat(AccessAckData, 8'd7, 32'hA7, 1'b0));
        tick();
        dev_rsp.d_valid = 1'b0;

        // Reset with two requests outstanding drops them
        req.d_ready = 1'b0;
        drive_a(Get, 8'd20, 32'h0000_0500);
        tick();
        drive_a(Get, 8'd21, 32'h0000_0504);
        tick();
        req.a_valid = 1'b0;
        dev_beat(mk_beat(AccessAckData, 8'd20, 32'h20, 1'b0));
        req.d_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_d_valid", 64'(rsp.d_valid), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_empty", 64'(rsp.d_valid), 64'd0);
        check("post_rst_a_ready", 64'(rsp.a_ready), 64'd1);
        check("post_rst_deny", 64'(deny_cnt), 64'd0);
        tick();
        dev_rsp.d_valid = 1'b0;

        // Back-to-back denied requests up to counter saturation
        allow = 1'b0;
        req.d_ready = 1'b1;
        drive_a(PutFullData, 8'd9, 32'h0000_0600);
        blk_beat(mk_beat(AccessAck, 8'd9, 32'h0, 1'b0));
        for (int i = 0; i < 65536; i++) begin
            if (i == 1000)  check("deny_1000", 64'(deny_cnt), 64'(exp_deny(1000)));
            if (i == 65535) check("deny_65535", 64'(deny_cnt), 64'(exp_deny(65535)));
            exp_q.push_back(mk_beat(AccessAck, 8'd9, 32'h0, 1'b0));
            tick();
        end
        req.a_valid = 1'b0;
        check("deny_saturated", 64'(deny_cnt), 64'(exp_deny(65536)));
        tick();
        blk_rsp.d_valid = 1'b0;
        allow = 1'b1;
        tick();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlul_iopmp_steer.md
TLUL_IOPMP_STEER -- requirements
Module: tlul_iopmp_steer

Interface
REQ-001 SHALL have parameter MaxOutst, default 4, meaning the maximum number of in-flight requests (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_i  input  tl_h2d_t  host A-channel plus d_ready.
REQ-005 SHALL have port rsp_o  output  tl_d2h_t  host D-channel plus a_ready.
REQ-006 SHALL have port allow_i  input  1  IOPMP verdict for the current req_i A beat; 1 = permitted.
REQ-007 SHALL have port dev_req_o  output  tl_h2d_t  request to the protected device.
REQ-008 SHALL have port dev_rsp_i  input  tl_d2h_t  response from the protected device.
REQ-009 SHALL have port blk_req_o  output  tl_h2d_t  request to the local responder, tlul_success_resp or an error variant.
REQ-010 SHALL have port blk_rsp_i  input  tl_d2h_t  response from the local responder.
REQ-011 SHALL have port deny_cnt_o  output  16  count of denied requests.

Function
REQ-012 SHALL select the A-channel target combinationally: RouteDev if allow_i=1, else RouteBlk.
REQ-013 SHALL copy all req_i A fields to the selected target; the selected a_valid = req_i.a_valid and the other target's a_valid = 0.
REQ-014 SHALL drive rsp_o.a_ready = selected target a_ready AND NOT fifo_full; the target's a_valid SHALL also be gated by NOT fifo_full.
REQ-015 SHALL push the route into an in-order route FIFO of depth MaxOutst on each A handshake (a_valid and a_ready).
REQ-016 SHALL, when the FIFO is non-empty, present on rsp_o all D fields of the head-route target, with d_ready passed to that target only.
REQ-017 SHALL hold the non-head target's d_ready at 0, and SHALL drive rsp_o.d_valid = 0 when the FIFO is empty.
REQ-018 SHALL pop the FIFO on each host D handshake (rsp_o.d_valid and req_i.d_ready).
REQ-019 SHALL perform a simultaneous push and pop in one cycle with the count unchanged, including when full (pop frees the slot that cycle; a_ready is computed from the registered full flag, so no same-cycle bypass).
REQ-020 SHALL wrap the read and write pointers modulo MaxOutst and keep the count in 0..MaxOutst.
REQ-021 SHALL add zero latency: both A and D paths are combinational; state consists only of the FIFO and the counter.
REQ-022 SHALL drop any D beat from a non-head target; it is not visible to the host.
REQ-023 SHALL NOT let allow_i change the route of already-accepted requests.

Reset
REQ-024 SHALL clear the pointers, count and deny counter asynchronously on rst_n=0.
REQ-025 SHALL, while in reset or directly after it, drive rsp_o.d_valid=0, rsp_o.a_ready = target a_ready, and deny_cnt_o=0.
REQ-026 SHALL lose in-flight requests on a mid-operation reset; the environment resets downstream targets together with this block.

Configuration
REQ-027 SHALL, with macro IOPMP_STEER_DENY_CNT_EN defined, increment deny_cnt_o by 1 on each A handshake routed to RouteBlk, saturating at 16'hFFFF.
REQ-028 SHALL, without IOPMP_STEER_DENY_CNT_EN, tie deny_cnt_o to 0 and build no counter register.

Structure
REQ-029 SHALL place typedef enum logic {RouteDev, RouteBlk} steer_route_e and the constant SteerMaxOutstDflt=4 in iopmp_pkg; TL types come from tlul_pkg.
REQ-030 SHALL implement the route FIFO as sub-module tlul_route_fifo (parameter Depth; push, pop, wdata, rdata, full, empty).

Verification
REQ-031 SHALL verify: Get to 0x100 with allow_i=1 -> forwarded to dev_req_o; device AccessAckData 0xDEADBEEF with source 3 reaches rsp_o unchanged.
REQ-032 SHALL verify: Put with allow_i=0 -> dev a_valid stays 0; the local responder's AccessAck with d_error=0 reaches the host; deny_cnt_o=1 when the macro is defined.
REQ-033 SHALL verify: four allowed requests with d_ready=0 -> rsp_o.a_ready=0 on the 5th beat; one pop and the next cycle accepts it.
REQ-034 SHALL verify: allow, deny, allow sequence with the responder answering before the device -> the host sees responses in issue order (dev, blk, dev).
REQ-035 SHALL verify: rst_n asserted with 2 requests outstanding -> rsp_o.d_valid=0 that cycle; the FIFO is empty after release.
REQ-036 SHALL verify: 65536 denied requests with the macro defined -> deny_cnt_o=16'hFFFF (saturated); without the macro it stays 0.
